vita_tx_unpacker: RTL and testbench
===================================

VITA_TX_UNPACKER -- requirements
Module: vita_tx_unpacker

Interface
REQ-001 SHALL have parameter BASE, default 0, settings-bus register base address.
REQ-002 SHALL have: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: clear  input  1  synchronous abort; returns FSM to HDR, clears sequence tracking.
REQ-005 SHALL have: set_stb/set_addr/set_data  input  1/8/32  settings bus.
REQ-006 SHALL have: data_i  input  36  packet word; [31:0] payload, [32] SOF, [33] EOF, [35:34] ignored.
REQ-007 SHALL have: src_rdy_i  input  1, dst_rdy_o  output  1  inbound handshake.
REQ-008 SHALL have: sample_o  output  32, time_o  output  64, send_at_o/sob_o/eob_o  output  1 each  sample tuple.
REQ-009 SHALL have: valid_o  output  1, ready_i  input  1  outbound handshake.
REQ-010 SHALL have: sid_err_o, len_err_o, seq_err_o  output  1 each  one-cycle error pulses; err_count_o  output  16.

Function
REQ-011 Transfer occurs on cycles where handshake valid and ready are both 1; no other cycle consumes or emits.
REQ-012 Header word (state HDR): [28] stream-ID present, [27] class-ID present, [26] trailer present, [25] SOB, [24] EOB, [23:22] TSI, [21:20] TSF, [19:16] packet count, [15:0] size in 32-bit words including header.
REQ-013 States: HDR -> SID (if [28]) -> SECS (if TSI!=0) -> TICS_HI, TICS_LO (if TSF!=0) -> BODY -> TRAILER (if [26]) -> HDR; DRAIN on errors; absent fields skipped in same order.
REQ-014 In HDR/SID/SECS/TICS_HI/TICS_LO/TRAILER/DRAIN, dst_rdy_o SHALL be 1; in BODY, dst_rdy_o = ready_i and valid_o = src_rdy_i, combinational, zero latency.
REQ-015 Words in HDR without SOF SHALL be discarded (stay in HDR); class-ID set SHALL pulse len_err_o and enter DRAIN.
REQ-016 time_o = {SECS word, TICS_LO word}; TICS_HI discarded; send_at_o = (TSI!=0)|(TSF!=0); all held for the whole packet.
REQ-017 sob_o = header SOB on first BODY sample only; eob_o = header EOB on last BODY sample only.
REQ-018 Word counter SHALL be 16-bit, start at 1 on header, increment per consumed word; body length = size - header words - trailer word.
REQ-019 SID word != register BASE+0 SHALL pulse sid_err_o and enter DRAIN (no samples emitted).
REQ-020 EOF before counter reaches size: emit that word if in BODY, pulse len_err_o, return to HDR; eob_o forced 1 on it.
REQ-021 Counter reaches size without EOF: pulse len_err_o, enter DRAIN; DRAIN exits to HDR after EOF word.
REQ-022 Size < header words + 1 (no body): pulse len_err_o, DRAIN.
REQ-023 err_count_o SHALL increment on each error pulse, saturate at 16'hFFFF, clear on clear.
REQ-024 Simultaneous clear and transfer: clear wins; word is consumed and dropped.

Reset
REQ-025 reset low SHALL asynchronously force state HDR, counters 0, time_o 0, err_count_o 0, all flags and pulses 0, BASE+0 register 0.
REQ-026 valid_o SHALL be 0 and dst_rdy_o 1 while in reset-released HDR state.
REQ-027 Reset mid-packet SHALL discard the remainder; the next word accepted is a SOF header.

Configuration
REQ-028 Macro VITA_TX_UNPACKER_SEQ_CHECK_EN defined: 4-bit expected count tracked; header count != expected pulses seq_err_o (packet still processed); expected = received+1 mod 16; first packet after reset/clear never errors.
REQ-029 Macro undefined: seq_err_o tied 0, no sequence logic, seq errors never counted.

Verification
REQ-030 SID=F00D1234 set; header 15F0000C with TSI/TSF, SID F00D1234, secs 0, tics 0/340, 6 samples, EOF on last -> 6 samples, time_o 0000000000000340, send_at_o 1, len_err_o 0.
REQ-031 Header with SID F00D0000 -> sid_err_o pulse, zero samples, err_count_o 1, next good packet passes.
REQ-032 Size 10, EOF on word 7 -> 4 samples (last with eob_o 1), one len_err_o pulse, back to HDR.
REQ-033 ready_i toggling 1/0 every cycle during body -> every sample emitted once, in order, no loss.
REQ-034 With macro: counts 0,1,3 -> single seq_err_o on third packet; without macro: none.
REQ-035 reset asserted mid-body then released; next packet complete -> outputs match REQ-030 values.

Source files
------------

// File: rtl/vita_tx_unpacker.sv
// Unpacks VITA-style TX packets (header/SID/time/body/trailer) into timed sample tuples.
// Define VITA_TX_UNPACKER_SEQ_CHECK_EN to enable packet-count sequence checking.
module vita_tx_unpacker #(
  parameter int unsigned BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [31:0] sample_o,
  output logic [63:0] time_o,
  output logic        send_at_o,
  output logic        sob_o,
  output logic        eob_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sid_err_o,
  output logic        len_err_o,
  output logic        seq_err_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_HDR, S_SID, S_SECS, S_TICS_HI, S_TICS_LO, S_BODY, S_TRAILER, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    size_q, size_d;
  logic                has_secs_q, has_secs_d;
  logic                has_tics_q, has_tics_d;
  logic                trl_q, trl_d;
  logic                sob_hdr_q, sob_hdr_d;
  logic                eob_hdr_q, eob_hdr_d;
  logic                first_q, first_d;
  logic [WORD_W-1:0]   secs_q, secs_d;
  logic [WORD_W-1:0]   tics_q, tics_d;
  logic                send_at_q, send_at_d;
  logic [WORD_W-1:0]   sid_reg_q, sid_reg_d;
  logic                sid_err_q, sid_err_d;
  logic                len_err_q, len_err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [WORD_W-1:0]   word;
  logic                sof, eof, xfer, hdr_take, seq_inc;
  logic                hdr_tsi, hdr_tsf;
  logic [CNT_W-1:0]    idx, hdr_words, min_size;
  logic                at_end, last_body;
  state_t              hdr_next, after_sid, after_secs;
  logic [1:0]          err_inc;
  logic [CNT_W:0]      err_sum;
  logic                unused_bits;

  assign word        = data_i[WORD_W-1:0];
  assign sof         = data_i[32];
  assign eof         = data_i[33];
  assign unused_bits = ^{data_i[35:34], word[19:16]};
  assign xfer        = src_rdy_i & dst_rdy_o;
  assign hdr_take    = xfer & (state_q == S_HDR) & sof & ~clear;

  // Header decode: field presence and the minimum legal size (at least one body word)
  assign hdr_tsi   = (word[23:22] != 2'd0);
  assign hdr_tsf   = (word[21:20] != 2'd0);
  assign hdr_words = CNT_W'(1) + CNT_W'(word[28]) + CNT_W'(hdr_tsi) + (hdr_tsf ? CNT_W'(2) : CNT_W'(0));
  assign min_size  = hdr_words + CNT_W'(word[26]) + CNT_W'(1);
  assign hdr_next  = word[28] ? S_SID : hdr_tsi ? S_SECS : hdr_tsf ? S_TICS_HI : S_BODY;
  assign after_sid  = has_secs_q ? S_SECS : has_tics_q ? S_TICS_HI : S_BODY;
  assign after_secs = has_tics_q ? S_TICS_HI : S_BODY;

  // idx is the 1-based position of the word currently offered
  assign idx       = cnt_q + CNT_W'(1);
  assign at_end    = (idx >= size_q);
  assign last_body = (idx == size_q - CNT_W'(trl_q));

  assign sid_reg_d = (set_stb && set_addr == 8'(BASE)) ? set_data : sid_reg_q;

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q    <= S_HDR;
      cnt_q      <= '0;
      size_q     <= '0;
      has_secs_q <= 1'b0;
      has_tics_q <= 1'b0;
      trl_q      <= 1'b0;
      sob_hdr_q  <= 1'b0;
      eob_hdr_q  <= 1'b0;
      first_q    <= 1'b0;
      secs_q     <= '0;
      tics_q     <= '0;
      send_at_q  <= 1'b0;
      sid_reg_q  <= '0;
      sid_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      has_secs_q <= has_secs_d;
      has_tics_q <= has_tics_d;
      trl_q      <= trl_d;
      sob_hdr_q  <= sob_hdr_d;
      eob_hdr_q  <= eob_hdr_d;
      first_q    <= first_d;
      secs_q     <= secs_d;
      tics_q     <= tics_d;
      send_at_q  <= send_at_d;
      sid_reg_q  <= sid_reg_d;
      sid_err_q  <= sid_err_d;
      len_err_q  <= len_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    has_secs_d = has_secs_q;
    has_tics_d = has_tics_q;
    trl_d      = trl_q;
    sob_hdr_d  = sob_hdr_q;
    eob_hdr_d  = eob_hdr_q;
    first_d    = first_q;
    secs_d     = secs_q;
    tics_d     = tics_q;
    send_at_d  = send_at_q;
    sid_err_d  = 1'b0;
    len_err_d  = 1'b0;
    if (clear) begin
      state_d = S_HDR;
      cnt_d   = '0;
      first_d = 1'b0;
    end else if (xfer) begin
      case (state_q)
        S_HDR: begin
          if (sof) begin
            cnt_d      = CNT_W'(1);
            size_d     = word[15:0];
            has_secs_d = hdr_tsi;
            has_tics_d = hdr_tsf;
            trl_d      = word[26];
            sob_hdr_d  = word[25];
            eob_hdr_d  = word[24];
            first_d    = 1'b1;
            secs_d     = '0;
            tics_d     = '0;
            send_at_d  = hdr_tsi | hdr_tsf;
            // Class-ID, undersized and single-word packets are all length faults
            if (word[27] || word[15:0] < min_size || eof) begin
              len_err_d = 1'b1;
              state_d   = eof ? S_HDR : S_DRAIN;
            end else begin
              state_d = hdr_next;
            end
          end
        end
        S_DRAIN: begin
          if (eof) state_d = S_HDR;
        end
        default: begin
          cnt_d = idx;
          if (state_q == S_SECS)    secs_d  = word;
          if (state_q == S_TICS_LO) tics_d  = word;
          if (state_q == S_BODY)    first_d = 1'b0;
          if (state_q == S_SID && word != sid_reg_q) begin
            sid_err_d = 1'b1;
            state_d   = eof ? S_HDR : S_DRAIN;
          end else if (eof && !at_end) begin
            len_err_d = 1'b1;
            state_d   = S_HDR;
          end else if (at_end) begin
            len_err_d = ~eof;
            state_d   = eof ? S_HDR : S_DRAIN;
          end else begin
            case (state_q)
              S_SID:     state_d = after_sid;
              S_SECS:    state_d = after_secs;
              S_TICS_HI: state_d = S_TICS_LO;
              S_TICS_LO: state_d = S_BODY;
              S_BODY:    if (last_body) state_d = S_TRAILER;
              default:   state_d = state_q;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin : outputs
    dst_rdy_o = 1'b1;
    valid_o   = 1'b0;
    sob_o     = 1'b0;
    eob_o     = 1'b0;
    sample_o  = word;
    if (state_q == S_BODY) begin
      dst_rdy_o = ready_i;
      valid_o   = src_rdy_i;
      sob_o     = first_q & sob_hdr_q;
      eob_o     = (last_body & eob_hdr_q) | (eof & ~at_end);
    end
  end

`ifdef VITA_TX_UNPACKER_SEQ_CHECK_EN
  logic       seq_valid_q, seq_valid_d;
  logic [3:0] seq_exp_q, seq_exp_d;
  logic       seq_err_q, seq_err_d;

  // Expected packet count follows the last received one; armed by the first header
  always_comb begin : seq_next
    seq_valid_d = seq_valid_q;
    seq_exp_d   = seq_exp_q;
    seq_err_d   = 1'b0;
    if (clear) begin
      seq_valid_d = 1'b0;
    end else if (hdr_take) begin
      seq_err_d   = seq_valid_q & (word[19:16] != seq_exp_q);
      seq_exp_d   = word[19:16] + 4'd1;
      seq_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : seq_reg
    if (!reset) begin
      seq_valid_q <= 1'b0;
      seq_exp_q   <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      seq_valid_q <= seq_valid_d;
      seq_exp_q   <= seq_exp_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_inc   = seq_err_d;
  assign seq_err_o = seq_err_q;
`else
  assign seq_inc   = hdr_take & 1'b0;
  assign seq_err_o = 1'b0;
`endif

  // Saturating error counter fed by every pulse raised this cycle
  assign err_inc   = 2'(sid_err_d) + 2'(len_err_d) + 2'(seq_inc);
  assign err_sum   = (CNT_W+1)'(err_cnt_q) + (CNT_W+1)'(err_inc);
  assign err_cnt_d = clear ? '0 : (err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0]);

  assign time_o      = {secs_q, tics_q};
  assign send_at_o   = send_at_q;
  assign sid_err_o   = sid_err_q;
  assign len_err_o   = len_err_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_vita_tx_unpacker.sv
// Directed self-checking bench for vita_tx_unpacker.
module tb_vita_tx_unpacker;

  logic        clk = 1'b0;
  logic        reset, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [35:0] data_i;
  logic        src_rdy_i, dst_rdy_o;
  logic [31:0] sample_o;
  logic [63:0] time_o;
  logic        send_at_o, sob_o, eob_o, valid_o, ready_i;
  logic        sid_err_o, len_err_o, seq_err_o;
  logic [15:0] err_count_o;

`ifdef VITA_TX_UNPACKER_SEQ_CHECK_EN
  localparam int SEQ_EXP = 1;
`else
  localparam int SEQ_EXP = 0;
`endif

  localparam logic [31:0] GOOD_SID = 32'hF00D1234;

  typedef struct {
    logic [31:0] d;
    logic        sob;
    logic        eob;
    logic        sa;
    logic [63:0] t;
  } rec_t;

  rec_t rq[$];
  int   n_sid, n_len, n_seq;
  int   checks = 0;
  int   failures = 0;
  logic tog_en = 1'b0;

  vita_tx_unpacker #(.BASE(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .sample_o(sample_o), .time_o(time_o), .send_at_o(send_at_o),
    .sob_o(sob_o), .eob_o(eob_o), .valid_o(valid_o), .ready_i(ready_i),
    .sid_err_o(sid_err_o), .len_err_o(len_err_o), .seq_err_o(seq_err_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  // Monitor: records emitted samples and error pulses away from the clock edge
  always begin
    rec_t r;
    @(negedge clk);
    #2;
    if (valid_o && ready_i) begin
      r.d = sample_o; r.sob = sob_o; r.eob = eob_o; r.sa = send_at_o; r.t = time_o;
      rq.push_back(r);
    end
    if (sid_err_o) n_sid++;
    if (len_err_o) n_len++;
    if (seq_err_o) n_seq++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic eof, input logic sof, input logic [31:0] w);
    return {2'b00, eof, sof, w};
  endfunction

  task automatic send_word(input logic [35:0] w);
    int  n = 0;
    logic done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (tog_en) ready_i = ~ready_i;
      data_i = w;
      src_rdy_i = 1'b1;
      #1;
      done = dst_rdy_o;
      n++;
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL handshake_timeout observed=%0d expected=accept", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      src_rdy_i = 1'b0;
    end
    #3;
  endtask

  task automatic clr_mon();
    rq.delete();
    n_sid = 0; n_len = 0; n_seq = 0;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  // 12-word packet: hdr, SID, secs 0, tics 0/340, six samples A000000x, trailer with EOF
  task automatic send_a(input logic [3:0] cnt, input logic [31:0] sid, input int nw);
    logic [35:0] w [12];
    w[0] = mk(1'b0, 1'b1, 32'h15F0000C | {12'd0, cnt, 16'd0});
    w[1] = mk(1'b0, 1'b0, sid);
    w[2] = mk(1'b0, 1'b0, 32'h0);
    w[3] = mk(1'b0, 1'b0, 32'h0);
    w[4] = mk(1'b0, 1'b0, 32'h340);
    for (int i = 0; i < 6; i++) w[5+i] = mk(1'b0, 1'b0, 32'hA000_0000 + 32'(i));
    w[11] = mk(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < nw; i++) send_word(w[i]);
  endtask

  task automatic chk_a(input string tag);
    int eobs = 0;
    chk({tag, "_nsamp"}, 64'(rq.size()), 64'd6);
    for (int i = 0; i < rq.size(); i++) begin
      if (rq[i].eob) eobs++;
      if (i < 6) chk({tag, "_data"}, 64'(rq[i].d), 64'(32'hA000_0000 + 32'(i)));
    end
    chk({tag, "_eobs"}, 64'(eobs), 64'd1);
    if (rq.size() > 0) begin
      chk({tag, "_sob0"}, 64'(rq[0].sob), 64'd0);
      chk({tag, "_eob_last"}, 64'(rq[rq.size()-1].eob), 64'd1);
      chk({tag, "_time"}, rq[rq.size()-1].t, 64'h0000_0000_0000_0340);
      chk({tag, "_send_at"}, 64'(rq[rq.size()-1].sa), 64'd1);
    end
    chk({tag, "_len_err"}, 64'(n_len), 64'd0);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    data_i = '0; src_rdy_i = 1'b0; ready_i = 1'b1;
    clr_mon();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    chk("rst_time", time_o, 64'd0);
    chk("rst_err_count", 64'(err_count_o), 64'd0);
    chk("rst_pulses", 64'({sid_err_o, len_err_o, seq_err_o, send_at_o}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    set_reg(8'd0, GOOD_SID);
    set_reg(8'd1, 32'h0);

    // Nominal packet with SID, integer and fractional time, trailer
    clr_mon();
    send_a(4'd0, GOOD_SID, 12);
    idle(3);
    chk_a("pkt_a");
    chk("pkt_a_err_count", 64'(err_count_o), 64'd0);

    // Wrong stream ID: drained, no samples, one error
    clr_mon();
    send_a(4'd1, 32'hF00D0000, 12);
    idle(3);
    chk("bad_sid_nsamp", 64'(rq.size()), 64'd0);
    chk("bad_sid_pulses", 64'(n_sid), 64'd1);
    chk("bad_sid_err_count", 64'(err_count_o), 64'd1);
    clr_mon();
    send_a(4'd2, GOOD_SID, 12);
    idle(3);
    chk_a("after_sid");

    // Size 10, EOF on word 7: four samples, forced eob, one length error
    clr_mon();
    send_word(mk(1'b0, 1'b1, 32'h1243000A));
    send_word(mk(1'b0, 1'b0, GOOD_SID));
    send_word(mk(1'b0, 1'b0, 32'h12345678));
    for (int i = 0; i < 4; i++) send_word(mk(i == 3, 1'b0, 32'hB000_0000 + 32'(i)));
    idle(3);
    chk("early_nsamp", 64'(rq.size()), 64'd4);
    for (int i = 0; i < rq.size(); i++) begin
      chk("early_data", 64'(rq[i].d), 64'(32'hB000_0000 + 32'(i)));
      chk("early_eob", 64'(rq[i].eob), 64'(i == 3));
      chk("early_sob", 64'(rq[i].sob), 64'(i == 0));
    end
    if (rq.size() > 0) chk("early_time", rq[0].t, 64'h1234_5678_0000_0000);
    chk("early_len_pulses", 64'(n_len), 64'd1);
    chk("early_err_count", 64'(err_count_o), 64'd2);
    clr_mon();
    send_a(4'd4, GOOD_SID, 12);
    idle(3);
    chk_a("after_early");

    // Downstream ready toggling every cycle
    clr_mon();
    tog_en = 1'b1;
    send_a(4'd5, GOOD_SID, 12);
    tog_en = 1'b0;
    ready_i = 1'b1;
    idle(3);
    chk_a("toggle");

    // Size reached without EOF: length error, drain to the EOF word
    clr_mon();
    send_word(mk(1'b0, 1'b1, 32'h00060003));
    send_word(mk(1'b0, 1'b0, 32'hC0));
    send_word(mk(1'b0, 1'b0, 32'hC1));
    send_word(mk(1'b1, 1'b0, 32'hC2));
    idle(3);
    chk("overrun_nsamp", 64'(rq.size()), 64'd2);
    chk("overrun_len_pulses", 64'(n_len), 64'd1);
    chk("overrun_err_count", 64'(err_count_o), 64'd3);

    // Class-ID present is rejected
    clr_mon();
    send_word(mk(1'b0, 1'b1, 32'h08070005));
    for (int i = 0; i < 4; i++) send_word(mk(i == 3, 1'b0, 32'hE0 + 32'(i)));
    idle(3);
    chk("classid_nsamp", 64'(rq.size()), 64'd0);
    chk("classid_len_pulses", 64'(n_len), 64'd1);
    chk("classid_err_count", 64'(err_count_o), 64'd4);

    // Clear mid-packet coincident with a transfer; then a stray non-SOF word
    clr_mon();
    send_a(4'd8, GOOD_SID, 2);
    clear = 1'b1;
    send_word(mk(1'b0, 1'b0, 32'h0));
    idle(1);
    clear = 1'b0;
    idle(1);
    chk("clear_err_count", 64'(err_count_o), 64'd0);
    send_word(mk(1'b0, 1'b0, 32'hDEADBEEF));
    send_a(4'd9, GOOD_SID, 12);
    idle(3);
    chk_a("after_clear");
    chk("after_clear_sid_pulses", 64'(n_sid), 64'd0);

    // Sequence counts 0,1,3 after clear
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    clr_mon();
    for (int p = 0; p < 3; p++) begin
      logic [3:0] c;
      c = (p == 2) ? 4'd3 : 4'(p);
      send_word(mk(1'b0, 1'b1, 32'h00000003 | {12'd0, c, 16'd0}));
      send_word(mk(1'b0, 1'b0, 32'hD0));
      send_word(mk(1'b1, 1'b0, 32'hD1));
    end
    idle(3);
    chk("seq_nsamp", 64'(rq.size()), 64'd6);
    chk("seq_pulses", 64'(n_seq), 64'(SEQ_EXP));
    chk("seq_err_count", 64'(err_count_o), 64'(SEQ_EXP));
    chk("seq_len_pulses", 64'(n_len), 64'd0);

    // Reset mid-body, then a complete packet
    clr_mon();
    send_a(4'd7, GOOD_SID, 8);
    @(negedge clk);
    src_rdy_i = 1'b0;
    reset = 1'b0;
    #2;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    chk("midrst_time", time_o, 64'd0);
    chk("midrst_err_count", 64'(err_count_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    set_reg(8'd0, GOOD_SID);
    idle(1);
    clr_mon();
    send_a(4'd0, GOOD_SID, 12);
    idle(3);
    chk_a("after_reset");
    chk("after_reset_err_count", 64'(err_count_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
